// File: rtl/fifo_arb_ctrl_if.sv
// fifo_arb_ctrl_if: producer/consumer/memory bundle for fifo_arb_ctrl; FIFO_ERR_FLAGS_EN adds err_clr/overflow/underflow
interface fifo_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_req0;
  logic [DATA_WIDTH-1:0] wr_data0;
  logic                  wr_gnt0;
  logic                  wr_req1;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic                  wr_gnt1;
  logic                  rd_en;
  logic                  mem_wclken;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output wr_req0, wr_data0, wr_req1, wr_data1, rd_en, err_clr,
    input  wr_gnt0, wr_gnt1, mem_wclken, mem_waddr, mem_wdata, mem_raddr,
           full, empty, almost_full, count, overflow, underflow
  );
  modport slave (
    input  wr_req0, wr_data0, wr_req1, wr_data1, rd_en, err_clr,
    output wr_gnt0, wr_gnt1, mem_wclken, mem_waddr, mem_wdata, mem_raddr,
           full, empty, almost_full, count, overflow, underflow
  );
`else
  modport master (
    output wr_req0, wr_data0, wr_req1, wr_data1, rd_en,
    input  wr_gnt0, wr_gnt1, mem_wclken, mem_waddr, mem_wdata, mem_raddr,
           full, empty, almost_full, count
  );
  modport slave (
    input  wr_req0, wr_data0, wr_req1, wr_data1, rd_en,
    output wr_gnt0, wr_gnt1, mem_wclken, mem_waddr, mem_wdata, mem_raddr,
           full, empty, almost_full, count
  );
`endif
endinterface

// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: round-robin two-writer arbiter plus pointer/status control for a fall-through FIFO memory; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module fifo_arb_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int AF_MARGIN  = 2
) (
  input logic       clk,
  input logic       rst_n,
  fifo_arb_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(FIFO_DEPTH - AF_MARGIN);
  logic [CW-1:0] r_wptr, r_rptr, r_count, w_count_nxt;
  logic          r_full, r_empty, r_af, r_pri;
  logic          w_gnt0, w_gnt1, w_wr, w_rd;
  // grant and accept decode; r_pri set means requester 1 wins a tie
  always_comb begin
    w_gnt0      = !r_full && bus.wr_req0 && (!bus.wr_req1 || !r_pri);
    w_gnt1      = !r_full && bus.wr_req1 && (!bus.wr_req0 || r_pri);
    w_wr        = w_gnt0 || w_gnt1;
    w_rd        = bus.rd_en && !r_empty;
    w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
  end
  // pointers, occupancy, registered flags and round-robin priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_pri   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr) r_pri <= w_gnt0;
      r_count <= w_count_nxt;
      r_full  <= w_count_nxt == DEPTH_C;
      r_empty <= w_count_nxt == '0;
      r_af    <= w_count_nxt >= AF_C;
    end
  end
  assign bus.wr_gnt0    = w_gnt0;
  assign bus.wr_gnt1    = w_gnt1;
  assign bus.mem_wclken = w_wr;
  assign bus.mem_wdata  = w_gnt1 ? bus.wr_data1 : bus.wr_data0;
  assign bus.mem_waddr  = r_wptr[ADDR_WIDTH-1:0];
  assign bus.mem_raddr  = r_rptr[ADDR_WIDTH-1:0];
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.almost_full = r_af;
  assign bus.count       = r_count;
`ifdef FIFO_ERR_FLAGS_EN
  logic r_ovf, r_unf;
  // sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_full && (bus.wr_req0 || bus.wr_req1)) || (r_ovf && !bus.err_clr);
      r_unf <= (r_empty && bus.rd_en) || (r_unf && !bus.err_clr);
    end
  end
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
`endif
endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb_fifo_arb_ctrl: queue-model scoreboard bench for fifo_arb_ctrl with directed and random traffic
module tb_fifo_arb_ctrl;
  localparam int DW = 8, D = 8, AW = 3, AFM = 2;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  fifo_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  fifo_arb_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .ADDR_WIDTH(AW), .AF_MARGIN(AFM))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] mem [D];
  always @(posedge clk) if (bus.mem_wclken) mem[bus.mem_waddr] <= bus.mem_wdata;
  typedef struct {
    logic g0, g1;
    logic [DW-1:0] wdata, head;
    logic [AW-1:0] waddr, raddr;
    logic [AW:0] cnt;
    logic full, empty, af, hv, ovf, unf;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  logic [DW-1:0] mq[$];
  bit pri;
  int wp, rp;
  bit m_ovf, m_unf;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask
  task automatic step(input bit r0, input logic [DW-1:0] d0, input bit r1, input logic [DW-1:0] d1,
                      input bit rd, input bit clr, output bit g0, output bit g1);
    exp_t e;
    int n;
    @(negedge clk);
    bus.wr_req0 = r0; bus.wr_data0 = d0;
    bus.wr_req1 = r1; bus.wr_data1 = d1;
    bus.rd_en = rd;
`ifdef FIFO_ERR_FLAGS_EN
    bus.err_clr = clr;
`endif
    n = mq.size();
    e.full = n == D; e.empty = n == 0; e.af = n >= D - AFM; e.cnt = n[AW:0];
    g0 = 0; g1 = 0;
    if (n < D) begin
      if (r0 && r1) begin
        if (pri) g1 = 1; else g0 = 1;
      end else if (r0) g0 = 1;
      else if (r1) g1 = 1;
    end
    e.g0 = g0; e.g1 = g1;
    e.wdata = g1 ? d1 : d0;
    e.waddr = AW'(wp % D); e.raddr = AW'(rp % D);
    e.hv = n > 0; e.head = n > 0 ? mq[0] : '0;
    e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
    m_ovf = ((r0 || r1) && n == D) || (m_ovf && !clr);
    m_unf = (rd && n == 0) || (m_unf && !clr);
    if (rd && n > 0) begin void'(mq.pop_front()); rp = (rp + 1) % (2 * D); end
    if (g0 || g1) begin mq.push_back(g1 ? d1 : d0); wp = (wp + 1) % (2 * D); pri = g0; end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #4;
    rst_n = 0;
    bus.wr_req0 = 0; bus.wr_data0 = 0; bus.wr_req1 = 0; bus.wr_data1 = 0; bus.rd_en = 0;
`ifdef FIFO_ERR_FLAGS_EN
    bus.err_clr = 0;
`endif
    mq.delete(); pri = 0; wp = 0; rp = 0; m_ovf = 0; m_unf = 0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_waddr", bus.mem_waddr, 0);
    chk("rst_raddr", bus.mem_raddr, 0);
    chk("rst_gnt", {bus.wr_gnt0, bus.wr_gnt1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt0", bus.wr_gnt0, e.g0);
      chk("gnt1", bus.wr_gnt1, e.g1);
      chk("wclken", bus.mem_wclken, e.g0 | e.g1);
      if (e.g0 | e.g1) chk("wdata", bus.mem_wdata, e.wdata);
      chk("waddr", bus.mem_waddr, e.waddr);
      chk("raddr", bus.mem_raddr, e.raddr);
      chk("count", bus.count, e.cnt);
      chk("full", bus.full, e.full);
      chk("empty", bus.empty, e.empty);
      chk("almost_full", bus.almost_full, e.af);
      if (e.hv) chk("rdata", mem[bus.mem_raddr], e.head);
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow", bus.overflow, e.ovf);
      chk("underflow", bus.underflow, e.unf);
`endif
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bit g0, g1, p0, p1, rd;
    logic [DW-1:0] pd0, pd1;
    do_reset();
    step(0, 0, 0, 0, 0, 0, g0, g1);
    for (int i = 0; i < 9; i++) step(1, DW'(8'h11 + i), 0, 0, 0, 0, g0, g1);
    step(0, 0, 1, 8'h77, 1, 0, g0, g1);
    step(0, 0, 1, 8'h77, 0, 0, g0, g1);
    repeat (10) step(0, 0, 0, 0, 1, 0, g0, g1);
    step(0, 0, 0, 0, 0, 1, g0, g1);
    step(1, 8'h5A, 0, 0, 1, 0, g0, g1);
    step(0, 0, 0, 0, 1, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, g0, g1);
    do_reset();
    repeat (10) step(1, 8'hA0, 1, 8'hB0, 0, 0, g0, g1);
    repeat (9) step(0, 0, 0, 0, 1, 0, g0, g1);
    for (int i = 0; i < 20; i++) begin
      step(i % 3 == 0, DW'(i * 7), i % 3 != 0, DW'(i * 13), 0, 0, g0, g1);
      step(0, 0, 0, 0, 1, 0, g0, g1);
    end
    for (int i = 0; i < 20; i++) step(1, DW'(i), 0, 0, i > 0, 0, g0, g1);
    p0 = 0; p1 = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) begin p0 = $urandom_range(0, 1) == 1; pd0 = DW'($urandom); end
      if (!p1) begin p1 = $urandom_range(0, 1) == 1; pd1 = DW'($urandom); end
      rd = (i / 100) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      step(p0, pd0, p1, pd1, rd, $urandom_range(0, 7) == 0, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    repeat (5) step(1, 8'hC3, 1, 8'h3C, 0, 0, g0, g1);
    do_reset();
    step(0, 0, 0, 0, 0, 0, g0, g1);
    @(negedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
